current_adc_sampler: RTL and testbench

//  Serial ADC front end for battery-current sensing; feeds current_b_out to the overcurrent/undercurrent checker.

---
 rtl/current_adc_sampler.sv | 110 +++++++++++
 tb/tb_current_adc_sampler.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/current_adc_sampler.sv
// current_adc_sampler: periodic 16-bit SPI read of the current ADC with leading-zero frame check.
// Define CURRENT_AVG_EN to insert a 2**AVG_LOG2-sample moving average before the output register.
module current_adc_sampler #(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 1000,
  parameter int AVG_LOG2      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adc_sdo,
  output logic        adc_sclk,
  output logic        adc_cs_n,
  output logic [11:0] current_b_out,
  output logic        current_valid,
  output logic        frame_err
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int PW = SAMPLE_PERIOD > 1 ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int QW = $clog2(2 * CLK_DIV);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE, QUIET} state_t;
  state_t state, state_nx;
  logic [PW-1:0] pcnt;
  logic [DW-1:0] div;
  logic [4:0] half;
  logic [QW-1:0] qc;
  logic [15:0] sr;
  logic pend, wrap, go, half_end, rise, shift_end, q_end, done, good;
  assign wrap      = pcnt == PW'(SAMPLE_PERIOD - 1);
  assign go        = wrap | pend;
  assign half_end  = div == DW'(CLK_DIV - 1);
  assign rise      = state == SHIFT && half_end && !half[0];
  assign shift_end = state == SHIFT && half_end && half == 5'd31;
  assign q_end     = qc == QW'(2 * CLK_DIV - 1);
  assign done      = state == DONE;
  assign good      = sr[15:12] == 4'd0;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE  ? (go ? SHIFT : IDLE) :
               state == SHIFT ? (shift_end ? DONE : SHIFT) :
               state == DONE  ? QUIET :
                                (q_end ? (go ? SHIFT : IDLE) : QUIET);
  always_comb begin
    adc_cs_n = state != SHIFT;
    adc_sclk = state != SHIFT || half[0];
  end
  // wraps landing outside IDLE/QUIET-exit collapse into one pending start
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pcnt <= '0;
      pend <= 1'b0;
    end else begin
      pcnt <= wrap ? '0 : pcnt + 1'b1;
      pend <= (state_nx == SHIFT && state != SHIFT) ? 1'b0 : go;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      div       <= '0;
      half      <= '0;
      qc        <= '0;
      sr        <= '0;
      frame_err <= 1'b0;
    end else begin
      div  <= (state != SHIFT || half_end) ? '0 : div + 1'b1;
      half <= state != SHIFT ? '0 : half_end ? half + 1'b1 : half;
      qc   <= state == QUIET ? qc + 1'b1 : '0;
      if (rise) sr <= {sr[14:0], adc_sdo};
      if (done) frame_err <= !good;
    end
`ifdef CURRENT_AVG_EN
  localparam int N  = 1 << AVG_LOG2;
  localparam int AW = 12 + AVG_LOG2;
  localparam int IW = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
  logic [11:0] win [N];
  logic [AW-1:0] acc;
  logic [IW-1:0] idx;
  logic full, upd;
  // running sum replaces the oldest slot; output is read from it one cycle later
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < N; i++) win[i] <= '0;
      acc           <= '0;
      idx           <= '0;
      full          <= 1'b0;
      upd           <= 1'b0;
      current_b_out <= '0;
      current_valid <= 1'b0;
    end else begin
      upd           <= done && good;
      current_valid <= upd && full;
      if (upd) current_b_out <= 12'(acc >> AVG_LOG2);
      if (done && good) begin
        acc      <= acc - AW'(win[idx]) + AW'(sr[11:0]);
        win[idx] <= sr[11:0];
        idx      <= IW'(idx + 1'b1) & IW'(N - 1);
        if (idx == IW'(N - 1)) full <= 1'b1;
      end
    end
`else
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      current_b_out <= '0;
      current_valid <= 1'b0;
    end else begin
      current_valid <= done && good;
      if (done && good) current_b_out <= sr[11:0];
    end
`endif
endmodule

// File: tb/tb_current_adc_sampler.sv
// tb_current_adc_sampler: directed frames into an SPI ADC model, checked against a frame-level model every cycle.
module tb_current_adc_sampler;
  localparam int CD = 2;
  localparam int SP = 100;
  localparam int WIN = 4;
  logic clk = 1'b0, rst = 1'b0, sdo = 1'b0;
  logic sclk0, cs0, val0, err0, sclk1, cs1, val1, err1;
  logic [11:0] out0, out1;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  current_adc_sampler #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP)) u0 (
    .clk(clk), .rst(rst), .adc_sdo(sdo), .adc_sclk(sclk0), .adc_cs_n(cs0),
    .current_b_out(out0), .current_valid(val0), .frame_err(err0));
  current_adc_sampler #(.CLK_DIV(CD), .SAMPLE_PERIOD(10)) u1 (
    .clk(clk), .rst(rst), .adc_sdo(1'b0), .adc_sclk(sclk1), .adc_cs_n(cs1),
    .current_b_out(out1), .current_valid(val1), .frame_err(err1));
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  logic [15:0] words[$];
  logic [15:0] word = '0;
  int bitn = 0;
  always @(negedge cs0) begin
    word = words.size() > 0 ? words.pop_front() : 16'h0000;
    bitn = 15;
    sdo = word[15];
  end
  always @(posedge sclk0)
    if (cs0 === 1'b0 && bitn > 0) begin
      bitn--;
      sdo = word[bitn];
    end
  int cyc = 0, done_at = -10, vat = -10, low_len = 0, rises = 0;
  logic pcs = 1'b1, psclk = 1'b1, exp_val = 1'b0, exp_err = 1'b0;
  logic [11:0] exp_out = '0, pend_out = '0;
  logic [15:0] fword = '0, dword = '0;
  logic [11:0] win[$];
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      pcs = 1'b1; psclk = 1'b1; exp_out = '0; exp_err = 1'b0;
      win.delete(); done_at = -10; vat = -10; low_len = 0; rises = 0;
    end else begin
      if (pcs && !cs0) begin fword = word; low_len = 0; rises = 0; end
      if (!cs0) begin
        low_len++;
        if (!psclk && sclk0) rises++;
      end else check("sclk_idle_high", 32'(sclk0), 32'd1);
      if (!pcs && cs0) begin
        check("cs_low_len", 32'(low_len), 32'(32 * CD));
        check("sclk_rises", 32'(rises), 32'd16);
        dword = fword;
        done_at = cyc;
      end
      if (cyc == done_at + 1) begin
        exp_err = dword[15:12] != 4'd0;
        if (!exp_err) begin
`ifdef CURRENT_AVG_EN
          int sum;
          win.push_back(dword[11:0]);
          if (win.size() > WIN) void'(win.pop_front());
          if (win.size() == WIN) begin
            sum = 0;
            foreach (win[i]) sum += int'(win[i]);
            pend_out = 12'(sum / WIN);
            vat = cyc + 1;
          end
`else
          pend_out = dword[11:0];
          vat = cyc;
`endif
        end
      end
      if (cyc == vat) exp_out = pend_out;
      exp_val = cyc == vat;
      check("valid", 32'(val0), 32'(exp_val));
      check("out", 32'(out0), 32'(exp_out));
      check("frame_err", 32'(err0), 32'(exp_err));
      pcs = cs0;
      psclk = sclk0;
    end
  end
  int l1 = 0, g1 = -1, fr1 = 0, vc1 = 0;
  logic p1 = 1'b1;
  always @(negedge clk)
    if (rst) begin
      p1 = 1'b1; l1 = 0; g1 = -1; fr1 = 0; vc1 = 0;
    end else begin
      if (val1) vc1++;
      if (p1 && !cs1) begin
        if (g1 >= 0) check("b2b_gap", 32'(g1), 32'(1 + 2 * CD));
`ifdef CURRENT_AVG_EN
        if (fr1 > 0) check("b2b_valids", 32'(vc1), 32'(fr1 >= WIN ? fr1 - WIN + 1 : 0));
`else
        if (fr1 > 0) check("b2b_valids", 32'(vc1), 32'(fr1));
`endif
        l1 = 0;
      end
      if (!p1 && cs1) begin
        check("b2b_low", 32'(l1), 32'(32 * CD));
        fr1++;
        g1 = 0;
      end
      if (cs1 && g1 >= 0) g1++;
      if (!cs1) l1++;
      p1 = cs1;
    end
  task automatic wait_cs(input logic lvl);
    int n = 0;
    while (cs0 !== lvl && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("cs_wait", 32'(cs0), 32'(lvl));
  endtask
  task automatic wait_done();
    wait_cs(1'b0);
    wait_cs(1'b1);
    repeat (3) @(negedge clk);
  endtask
  task automatic start_delay();
    int n = 0;
    while (cs0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("start_delay", 32'(n), 32'(SP));
  endtask
  task automatic reset_state(input string tag);
    check({tag, "_cs_n"}, 32'(cs0), 32'd1);
    check({tag, "_sclk"}, 32'(sclk0), 32'd1);
    check({tag, "_out"}, 32'(out0), 32'd0);
    check({tag, "_valid"}, 32'(val0), 32'd0);
    check({tag, "_err"}, 32'(err0), 32'd0);
  endtask
  initial begin
    #1 rst = 1'b1;
    words = '{16'h09C4, 16'h89C4, 16'h0064, 16'h0ABC, 16'h0FFF, 16'h0FFF, 16'h0FFF, 16'h0FFF, 16'h0320};
    repeat (3) @(negedge clk);
    reset_state("reset");
    rst = 1'b0;
    start_delay();
    wait_done();
`ifndef CURRENT_AVG_EN
    check("lit_2500", 32'(out0), 32'd2500);
`endif
    check("lit_err0", 32'(err0), 32'd0);
    wait_done();
    check("lit_err1", 32'(err0), 32'd1);
`ifndef CURRENT_AVG_EN
    check("lit_hold", 32'(out0), 32'd2500);
`endif
    wait_done();
    check("lit_err_clear", 32'(err0), 32'd0);
`ifndef CURRENT_AVG_EN
    check("lit_100", 32'(out0), 32'd100);
`endif
    wait_cs(1'b0);
    repeat (7) @(posedge sclk0);
    #1 rst = 1'b1;
    #1 reset_state("midreset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    start_delay();
    repeat (4) wait_done();
    check("lit_4095", 32'(out0), 32'd4095);
    wait_done();
`ifdef CURRENT_AVG_EN
    check("lit_avg_3271", 32'(out0), 32'd3271);
`else
    check("lit_800", 32'(out0), 32'd800);
`endif
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #500000;
    miscompares++;
    $display("FAIL watchdog: got timeout, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end
endmodule
